// File: rtl/dmem_dma_if.sv
// Request/status and data-memory signals of the word-copy DMA.
// No latency of its own: plain wires grouped for port connection.
// No backpressure: the memory is always ready and requests are single pulses.
// Optional DMEM_DMA_CHECKSUM_EN adds the checksum output.
interface dmem_dma_if #(
   parameter int n = 32,
   parameter int L = 7
);
   logic         start;
   logic [n-1:0] src_addr;
   logic [n-1:0] dst_addr;
   logic [L-1:0] len;
   logic         busy;
   logic         done;
   logic         err;
   logic [n-1:0] mem_add;
   logic [n-1:0] mem_write_data;
   logic         mem_write_enable;
   logic [n-1:0] mem_read_data;
`ifdef DMEM_DMA_CHECKSUM_EN
   logic [n-1:0] checksum;
`endif

   // The DMA engine: takes requests, drives the memory port.
   modport slave (
`ifdef DMEM_DMA_CHECKSUM_EN
      output checksum,
`endif
      input  start, src_addr, dst_addr, len, mem_read_data,
      output busy, done, err, mem_add, mem_write_data, mem_write_enable
   );

   // The system side: issues requests and hosts the memory.
   modport master (
`ifdef DMEM_DMA_CHECKSUM_EN
      input  checksum,
`endif
      output start, src_addr, dst_addr, len, mem_read_data,
      input  busy, done, err, mem_add, mem_write_data, mem_write_enable
   );
endinterface

// File: rtl/dmem_dma.sv
// Word-copy DMA: copies len words src->dst over the data-memory port, ascending.
// Latency: 2 cycles per word; done pulses 2*len+2 cycles after start (2 for len==0).
// No backpressure: start is only sampled in IDLE; requests while busy are dropped.
// Optional DMEM_DMA_CHECKSUM_EN adds a running sum of the copied words.
module dmem_dma #(
   parameter int n = 32,
   parameter int r = 6,
   parameter int L = 7
) (
   input logic       clk,
   input logic       rst_n,
   dmem_dma_if.slave bus
);
   typedef enum logic [1:0] {IDLE, READ, WRITE, FINISH} state_t;

   localparam logic [L-1:0] MAX_LEN = L'(1 << r);

   state_t       state_q;
   logic [n-1:0] sptr_q;
   logic [n-1:0] dptr_q;
   logic [L-1:0] cnt_q;
   logic [n-1:0] data_q;
   logic [n-1:0] add_q;
   logic         we_q;
   logic         busy_q;
   logic         done_q;
   logic         err_q;
`ifdef DMEM_DMA_CHECKSUM_EN
   logic [n-1:0] checksum_q;
`endif

   logic         bad_req;
   logic [n-1:0] sptr_nx;
   logic [n-1:0] dptr_nx;

   // Request validity and pointer advance (wrap modulo 2**n is intended).
   assign bad_req = (bus.src_addr[1:0] != 2'b00) || (bus.dst_addr[1:0] != 2'b00) ||
                    (bus.len > MAX_LEN);
   assign sptr_nx = sptr_q + n'(4);
   assign dptr_nx = dptr_q + n'(4);

   // Copy FSM; all outputs are registered so the memory sees clean strobes,
   // and the async reset drops the write strobe before any partial commit.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         sptr_q     <= '0;
         dptr_q     <= '0;
         cnt_q      <= '0;
         data_q     <= '0;
         add_q      <= '0;
         we_q       <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         err_q      <= 1'b0;
`ifdef DMEM_DMA_CHECKSUM_EN
         checksum_q <= '0;
`endif
      end else begin
         case (state_q)
            IDLE: begin
               done_q <= 1'b0;
               err_q  <= 1'b0;
               we_q   <= 1'b0;
               if (bus.start) begin
                  sptr_q <= bus.src_addr;
                  dptr_q <= bus.dst_addr;
                  cnt_q  <= bus.len;
                  if (bad_req) begin
                     err_q <= 1'b1;
                  end else begin
                     busy_q <= 1'b1;
`ifdef DMEM_DMA_CHECKSUM_EN
                     checksum_q <= '0;
`endif
                     if (bus.len == '0) begin
                        state_q <= FINISH;
                     end else begin
                        add_q   <= bus.src_addr;
                        state_q <= READ;
                     end
                  end
               end
            end
            READ: begin
               // Memory read is combinational: capture it and present the write.
               data_q  <= bus.mem_read_data;
               add_q   <= dptr_q;
               we_q    <= 1'b1;
               state_q <= WRITE;
            end
            WRITE: begin
               we_q   <= 1'b0;
               sptr_q <= sptr_nx;
               dptr_q <= dptr_nx;
               cnt_q  <= cnt_q - L'(1);
`ifdef DMEM_DMA_CHECKSUM_EN
               checksum_q <= checksum_q + data_q;
`endif
               if (cnt_q == L'(1)) begin
                  state_q <= FINISH;
               end else begin
                  add_q   <= sptr_nx;
                  state_q <= READ;
               end
            end
            FINISH: begin
               busy_q  <= 1'b0;
               done_q  <= 1'b1;
               state_q <= IDLE;
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign bus.busy             = busy_q;
   assign bus.done             = done_q;
   assign bus.err              = err_q;
   assign bus.mem_add          = add_q;
   assign bus.mem_write_data   = data_q;
   assign bus.mem_write_enable = we_q;
`ifdef DMEM_DMA_CHECKSUM_EN
   assign bus.checksum         = checksum_q;
`endif
endmodule

// File: tb/tb_dmem_dma.sv
// Bench for dmem_dma: table of copy requests against a behavioural memory,
// plus hand sequences for mid-copy reset. Define DMEM_DMA_CHECKSUM_EN to
// also check the checksum output.
module tb_dmem_dma;
   logic clk = 1'b0;
   logic rst_n;
   logic load_mem;
   logic [31:0] mem [0:255];
   logic [31:0] expm [0:255];

   always #5 clk = ~clk;

   dmem_dma_if bus ();

   dmem_dma dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   // Initial memory image: words 0..3 = 1..4, 4..7 = 0x11..0x44, rest a tag.
   function automatic logic [31:0] img(input int i);
      if (i < 4) return 32'(i + 1);
      else if (i < 8) return 32'(17 * (i - 3));
      else return 32'hC0DE_0000 + 32'(i);
   endfunction

   // 256-word memory: combinational read, posedge write.
   assign bus.mem_read_data = mem[bus.mem_add[9:2]];
   always @(posedge clk) begin
      if (load_mem) begin
         for (int i = 0; i < 256; i++) mem[i] <= img(i);
      end else if (bus.mem_write_enable) begin
         mem[bus.mem_add[9:2]] <= bus.mem_write_data;
      end
   end

   int nchk = 0;
   int nerr = 0;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      nchk++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   typedef struct {
      logic [31:0] src;
      logic [31:0] dst;
      logic [6:0]  len;
      bit          is_err;
      int          lat;
      int          restart;
   } vec_t;

   vec_t vecs [10];

   task automatic load_image();
      @(negedge clk);
      load_mem = 1'b1;
      @(negedge clk);
      load_mem = 1'b0;
   endtask

   // Reference: strictly ascending word copy on the initial image.
   task automatic model(input logic [31:0] s, input logic [31:0] d, input int nw,
                        output logic [31:0] sum);
      logic [31:0] sa, da;
      sum = 32'h0;
      for (int i = 0; i < 256; i++) expm[i] = img(i);
      for (int k = 0; k < nw; k++) begin
         sa = s + 32'(4 * k);
         da = d + 32'(4 * k);
         expm[da[9:2]] = expm[sa[9:2]];
         sum = sum + expm[da[9:2]];
      end
   endtask

   function automatic int mem_diffs();
      int cnt = 0;
      for (int i = 0; i < 256; i++) if (mem[i] !== expm[i]) cnt++;
      return cnt;
   endfunction

   // Issue one request and watch a bounded window of cycles after it.
   task automatic run_req(input vec_t v, output int first_done, output int done_cnt,
                          output int err_cnt, output int busy_cnt, output int we_cnt);
      int window;
      first_done = 0; done_cnt = 0; err_cnt = 0; busy_cnt = 0; we_cnt = 0;
      window = v.is_err ? 8 : v.lat + 4;
      @(negedge clk);
      bus.src_addr = v.src;
      bus.dst_addr = v.dst;
      bus.len      = v.len;
      bus.start    = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      for (int c = 1; c <= window; c++) begin
         if (bus.done) begin
            done_cnt++;
            if (first_done == 0) first_done = c;
         end
         if (bus.err) err_cnt++;
         if (bus.busy) busy_cnt++;
         if (bus.mem_write_enable) we_cnt++;
         bus.start = (c == v.restart);
         @(negedge clk);
      end
      bus.start = 1'b0;
   endtask

   initial begin
      int fd, dc, ec, bc, wc;
      logic [31:0] sum;
      logic [31:0] csum_exp;
      vec_t v;

      //              src           dst           len     err  lat  restart
      vecs[0] = '{32'h0000_0010, 32'h0000_0040, 7'd4,  1'b0, 10,  0};
      vecs[1] = '{32'h0000_0010, 32'h0000_0040, 7'd0,  1'b0, 2,   0};
      vecs[2] = '{32'h0000_0012, 32'h0000_0040, 7'd1,  1'b1, 0,   0};
      vecs[3] = '{32'h0000_0010, 32'h0000_0040, 7'd65, 1'b1, 0,   0};
      vecs[4] = '{32'h0000_0010, 32'h0000_0042, 7'd1,  1'b1, 0,   0};
      vecs[5] = '{32'h0000_0000, 32'h0000_0004, 7'd3,  1'b0, 8,   0};
      vecs[6] = '{32'h0000_0100, 32'h0000_0000, 7'd64, 1'b0, 130, 0};
      vecs[7] = '{32'hFFFF_FFFC, 32'h0000_0200, 7'd2,  1'b0, 6,   0};
      vecs[8] = '{32'h0000_0010, 32'h0000_0080, 7'd2,  1'b0, 6,   3};
      vecs[9] = '{32'h0000_0010, 32'h0000_0080, 7'd2,  1'b0, 6,   5};

      rst_n        = 1'b0;
      load_mem     = 1'b0;
      bus.start    = 1'b0;
      bus.src_addr = '0;
      bus.dst_addr = '0;
      bus.len      = '0;
      csum_exp     = 32'h0;
      #12;
      check("reset_flags", {28'h0, bus.busy, bus.done, bus.err, bus.mem_write_enable}, 32'h0);
      check("reset_add", bus.mem_add, 32'h0);
      check("reset_wdata", bus.mem_write_data, 32'h0);
`ifdef DMEM_DMA_CHECKSUM_EN
      check("reset_csum", bus.checksum, 32'h0);
`endif
      @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < 10; i++) begin
         v = vecs[i];
         load_image();
         model(v.src, v.dst, v.is_err ? 0 : int'(v.len), sum);
         if (!v.is_err) csum_exp = sum;
         run_req(v, fd, dc, ec, bc, wc);
         check($sformatf("v%0d_done_lat", i), 32'(fd), 32'(v.lat));
         check($sformatf("v%0d_done_cnt", i), 32'(dc), v.is_err ? 32'd0 : 32'd1);
         check($sformatf("v%0d_err_cnt", i), 32'(ec), v.is_err ? 32'd1 : 32'd0);
         check($sformatf("v%0d_busy_cyc", i), 32'(bc), v.is_err ? 32'd0 : 32'(v.lat - 1));
         check($sformatf("v%0d_we_cyc", i), 32'(wc), v.is_err ? 32'd0 : 32'(v.len));
         check($sformatf("v%0d_mem_diffs", i), 32'(mem_diffs()), 32'd0);
`ifdef DMEM_DMA_CHECKSUM_EN
         check($sformatf("v%0d_csum", i), bus.checksum, csum_exp);
         if (i == 0) check("v0_csum_hand", bus.checksum, 32'h0000_00AA);
`endif
         if (i == 0) begin
            check("v0_dst_words", {mem[16][7:0], mem[17][7:0], mem[18][7:0], mem[19][7:0]},
                  32'h1122_3344);
            check("v0_src_words", {mem[4][7:0], mem[5][7:0], mem[6][7:0], mem[7][7:0]},
                  32'h1122_3344);
         end
         if (i == 5) check("v5_overlap", {8'h0, mem[1][7:0], mem[2][7:0], mem[3][7:0]},
                           32'h0001_0101);
      end

      // Mid-copy reset: len=8, reset asserted during the third WRITE (cycle 6).
      load_image();
      @(negedge clk);
      bus.src_addr = 32'h10;
      bus.dst_addr = 32'h40;
      bus.len      = 7'd8;
      bus.start    = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      for (int c = 1; c < 6; c++) @(negedge clk);
      check("rst_mid_we_before", {31'h0, bus.mem_write_enable}, 32'h1);
      rst_n = 1'b0;
      #1;
      check("rst_mid_flags", {28'h0, bus.busy, bus.done, bus.err, bus.mem_write_enable}, 32'h0);
      check("rst_mid_add", bus.mem_add, 32'h0);
      check("rst_mid_wdata", bus.mem_write_data, 32'h0);
`ifdef DMEM_DMA_CHECKSUM_EN
      check("rst_mid_csum", bus.checksum, 32'h0);
`endif
      @(negedge clk);
      @(negedge clk);
      model(32'h10, 32'h40, 2, sum);
      check("rst_mid_mem_diffs", 32'(mem_diffs()), 32'd0);
      rst_n = 1'b1;

      // A fresh request after reset completes normally.
      v = '{32'h0000_0010, 32'h0000_0040, 7'd2, 1'b0, 6, 0};
      load_image();
      model(v.src, v.dst, 2, sum);
      run_req(v, fd, dc, ec, bc, wc);
      check("post_rst_done_lat", 32'(fd), 32'd6);
      check("post_rst_done_cnt", 32'(dc), 32'd1);
      check("post_rst_mem_diffs", 32'(mem_diffs()), 32'd0);
`ifdef DMEM_DMA_CHECKSUM_EN
      check("post_rst_csum", bus.checksum, 32'h0000_0033);
`endif

      $display("Result: errors=%0d of %0d checks", nerr, nchk);
      $finish;
   end
endmodule

// File: doc/dmem_dma.md
Name: dmem_dma

Overview:
- Word-copy DMA initiator that masters the data-memory port. It drives the address, write-data and write-enable signals and samples the combinational read-data return.
- Copies a block of words from a source region to a destination region of the data segment. Sits beside the CPU datapath; the CPU/mux grants it the dmem port while busy is high.
- Uses the memory's protocol: combinational word-aligned read; write committed on the posedge when write-enable is high.

Parameters:
- n, 32, data/address width (matches memory word width)
- r, 6, memory address bits; sizes the largest legal block at 2**r words
- L, 7, width of the length field (r+1, so 0..64 words can be encoded)

Ports:
- clk  input  1  system clock, all state updates on posedge
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request pulse; sampled only in IDLE
- src_addr  input  n  byte address of first source word
- dst_addr  input  n  byte address of first destination word
- len  input  L  number of words to copy
- busy  output  1  high from the cycle after an accepted start until DONE exits
- done  output  1  one-cycle pulse on completion
- err  output  1  one-cycle pulse on a rejected request
- mem_add  output  n  byte address to the memory
- mem_write_data  output  n  write data to the memory
- mem_write_enable  output  1  memory write strobe
- mem_read_data  input  n  combinational read data from the memory

Behaviour:
- Reset (async, rst_n=0):
  - State goes to IDLE.
  - busy, done, err, mem_write_enable, mem_add, mem_write_data and internal counters all go to 0 immediately, without waiting for clk.
  - Reset mid-transfer abandons the copy. Words already written stay written; no partial write can occur because write_enable drops asynchronously.
- States: IDLE, READ, WRITE, FINISH.
- IDLE:
  - mem_write_enable=0.
  - On start=1 latch src_addr, dst_addr and len into sptr, dptr and cnt.
  - If src_addr[1:0]!=0, dst_addr[1:0]!=0, or len>2**r: pulse err next cycle and stay in IDLE.
  - Else if len==0: go to FINISH with no memory access.
  - Else go to READ.
- READ (1 cycle):
  - mem_add=sptr, mem_write_enable=0.
  - At posedge capture mem_read_data into the data register, then go to WRITE.
- WRITE (1 cycle):
  - mem_add=dptr, mem_write_data=data register, mem_write_enable=1.
  - At posedge the memory commits the word; sptr+=4, dptr+=4, cnt-=1.
  - If cnt becomes 0 go to FINISH, else go to READ.
- FINISH (1 cycle): done=1, busy=0 on exit, return to IDLE.
- Throughput: 2 cycles per word. Total latency from start to the done pulse is 2*len+2 cycles for len>=1, and 2 cycles for len==0.
- Pointers increment modulo 2**n; wrap-around is not an error.
- Overlapping regions: the copy is strictly ascending, word by word. dst<src is therefore correct. dst>src with overlap replicates the source words; this is defined behaviour, not an error.
- start while busy: ignored, with no err pulse.
- start in the same cycle FINISH exits: ignored, because the request is sampled only in IDLE.
- mem_write_enable is asserted only in WRITE, never in any other state.

Optional Feature:
- Macro: DMEM_DMA_CHECKSUM_EN.
- When defined:
  - Extra output checksum [n-1:0].
  - Cleared on every accepted start.
  - In each WRITE cycle, checksum += copied word (mod 2**n).
  - Holds its value after done until the next accepted start; reset to 0.
- When undefined: port and logic absent; all other behaviour identical.

Test Plan:
- Preload memory words 4..7 with 0x11,0x22,0x33,0x44. Start with src=0x10, dst=0x40, len=4:
  - busy for 9 cycles, done pulse at cycle 10.
  - Words 16..19 = 0x11..0x44, source unchanged.
  - With checksum enabled, checksum=0xAA.
- len=0, src=0x10, dst=0x40:
  - done pulses 2 cycles after start.
  - mem_write_enable never high, memory unchanged.
- src=0x12, len=1 (misaligned); separately len=65:
  - err pulses once, busy never rises, no write.
- Overlap: mem[0..3]=1,2,3,4, src=0x0, dst=0x4, len=3 → mem[1..3]=1,1,1.
- Mid-copy reset: len=8, drop rst_n during the third WRITE:
  - All outputs go to 0 asynchronously.
  - Only the first 2 destination words are modified.
  - A new start after reset completes normally.
- Pulse start again at cycle 3 of a len=2 transfer: ignored; exactly one done pulse and correct data.
